// File: rtl/alu_writeback_ctrl.sv
// Issue/commit controller for the datapath ALU: accepts ops, waits ALU latency, commits
// mul/div results to HI/LO and 32-bit results to the register-file write port.
// Optional zero-bubble accept on writeback retire: define ALU_WB_BYPASS_EN.
module alu_writeback_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [4:0]  opcode,
  input  logic [3:0]  rd_idx,
  output logic [4:0]  alu_opcode,
  input  logic [63:0] alu_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_idx,
  output logic [31:0] wb_data,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy
);

  localparam int CNT_W = $clog2(16) + 1;

  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;

  if (MUL_LAT < 1 || MUL_LAT > 16) begin : g_bad_mul_lat
    $error("alu_writeback_ctrl: MUL_LAT must be in 1..16");
  end
  if (DIV_LAT < 1 || DIV_LAT > 16) begin : g_bad_div_lat
    $error("alu_writeback_ctrl: DIV_LAT must be in 1..16");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         alu_opcode_q, alu_opcode_d;
  logic [3:0]         wb_idx_q, wb_idx_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               accept;

  function automatic logic is_alu_op(input logic [4:0] op);
    return ((op >= 5'b00011) && (op <= 5'b01110)) || (op == 5'b10001) || (op == 5'b10010);
  endfunction

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // the offering side holds its payload stable until that edge, valid never depends on ready.
`ifdef ALU_WB_BYPASS_EN
  assign op_ready = (state_q == S_IDLE) || ((state_q == S_WB) && wb_ready);
`else
  assign op_ready = (state_q == S_IDLE);
`endif

  assign accept     = op_valid && op_ready;
  assign wb_valid   = (state_q == S_WB);
  assign busy       = (state_q != S_IDLE);
  assign alu_opcode = alu_opcode_q;
  assign wb_idx     = wb_idx_q;
  assign wb_data    = wb_data_q;
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_opcode_d = alu_opcode_q;
    wb_idx_d     = wb_idx_q;
    wb_data_d    = wb_data_q;
    hi_d         = hi_q;
    lo_d         = lo_q;

    case (state_q)
      S_EXEC: begin
        if (cnt_q == '0) begin
          // alu_opcode_q still holds the op in flight; it decides where the result goes
          if ((alu_opcode_q == OP_MUL) || (alu_opcode_q == OP_DIV)) begin
            hi_d    = alu_result[63:32];
            lo_d    = alu_result[31:0];
            state_d = S_IDLE;
          end else begin
            wb_data_d = alu_result[31:0];
            state_d   = S_WB;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WB: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // An accept (from IDLE, or from WB on the retire edge) overrides the default path
    if (accept) begin
      alu_opcode_d = opcode;
      wb_idx_d     = rd_idx;
      if (is_alu_op(opcode)) begin
        cnt_d   = '0;
        state_d = S_EXEC;
      end else if (opcode == OP_MUL) begin
        cnt_d   = CNT_W'(MUL_LAT - 1);
        state_d = S_EXEC;
      end else if (opcode == OP_DIV) begin
        cnt_d   = CNT_W'(DIV_LAT - 1);
        state_d = S_EXEC;
      end else if (opcode == OP_MFHI) begin
        wb_data_d = hi_q;
        state_d   = S_WB;
      end else if (opcode == OP_MFLO) begin
        wb_data_d = lo_q;
        state_d   = S_WB;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // wb_data_q doubles as the low word of Z; the high word has no consumer so it is not kept
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      alu_opcode_q <= '0;
      wb_idx_q     <= '0;
      wb_data_q    <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      wb_idx_q     <= wb_idx_d;
      wb_data_q    <= wb_data_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

endmodule

// File: tb/tb_alu_writeback_ctrl.sv
// Directed bench for alu_writeback_ctrl: writebacks checked by a scoreboard monitor,
// HI/LO, handshake timing and reset behaviour checked inline by the driver.
module tb_alu_writeback_ctrl;

  logic        clk;
  logic        clr_n;
  logic        op_valid;
  logic        op_ready;
  logic [4:0]  opcode;
  logic [3:0]  rd_idx;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_idx;
  logic [31:0] wb_data;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];

  alu_writeback_ctrl #(.MUL_LAT(4), .DIV_LAT(8)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .opcode     (opcode),
    .rd_idx     (rd_idx),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_idx     (wb_idx),
    .wb_data    (wb_data),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer an op and return once it has been accepted; waits = negedges seen with op_ready low
  task automatic issue(input logic [4:0] op, input logic [3:0] rd, output int waits);
    op_valid = 1'b1;
    opcode   = op;
    rd_idx   = rd;
    waits    = 0;
    @(negedge clk);
    while (!op_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!op_ready) begin
      errors++;
      checks++;
      $display("FAIL issue_timeout: op_ready never rose for opcode 0x%0h", op);
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  // scoreboard monitor: a writeback transfer is due on the next rising edge
  always @(negedge clk) begin
    if (clr_n && wb_valid && wb_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got idx=%0d data=0x%0h expected no writeback", wb_idx, wb_data);
      end else begin
        logic [35:0] exp;
        exp = exp_q.pop_front();
        if ({wb_idx, wb_data} !== exp) begin
          errors++;
          $display("FAIL wb_data: got idx=%0d data=0x%0h expected idx=%0d data=0x%0h",
                   wb_idx, wb_data, exp[35:32], exp[31:0]);
        end
      end
    end
  end

  initial begin
    int w;
    clr_n      = 1'b0;
    op_valid   = 1'b0;
    opcode     = '0;
    rd_idx     = '0;
    alu_result = '0;
    wb_ready   = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_op_ready",   op_ready,   1);
    check("rst_wb_valid",   wb_valid,   0);
    check("rst_busy",       busy,       0);
    check("rst_hi",         hi_out,     0);
    check("rst_lo",         lo_out,     0);
    check("rst_alu_opcode", alu_opcode, 0);
    clr_n = 1'b1;
    tick();

    // add with writeback stalled for three cycles
    alu_result = 64'h7;
    exp_q.push_back({4'd5, 32'h7});
    issue(5'b00011, 4'd5, w);
    check("add_alu_opcode", alu_opcode, 5'b00011);
    check("add_wb_not_yet", wb_valid, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("add_wb_valid", wb_valid, 1);
      check("add_wb_idx",   wb_idx,   5);
      check("add_wb_data",  wb_data,  32'h7);
      alu_result = 64'hDEAD_BEEF_0BAD_F00D;
      tick();
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check("add_retired", wb_valid, 0);

    // mul, 4-cycle latency
    alu_result = 64'h0000_0001_FFFF_FFFE;
    issue(5'b01111, 4'd1, w);
    for (int i = 0; i < 4; i++) begin
      check("mul_op_ready_low", op_ready, 0);
      check("mul_no_wb", wb_valid, 0);
      if (i < 3) tick();
    end
    check("mul_hi_before", hi_out, 0);
    tick();
    check("mul_hi", hi_out, 32'h1);
    check("mul_lo", lo_out, 32'hFFFF_FFFE);
    check("mul_op_ready", op_ready, 1);

    // mflo / mfhi read the committed values
    wb_ready = 1'b1;
    exp_q.push_back({4'd2, 32'hFFFF_FFFE});
    issue(5'b11001, 4'd2, w);
    check("mflo_wb_valid", wb_valid, 1);
    tick();
    exp_q.push_back({4'd9, 32'h1});
    issue(5'b11000, 4'd9, w);
    tick();
    wb_ready = 1'b0;

    // div, 8-cycle latency
    alu_result = {32'h3, 32'h10};
    issue(5'b10000, 4'd3, w);
    for (int i = 0; i < 7; i++) tick();
    check("div_hi_before", hi_out, 32'h1);
    check("div_busy", busy, 1);
    tick();
    check("div_hi", hi_out, 32'h3);
    check("div_lo", lo_out, 32'h10);

    // reset in the middle of a div
    alu_result = {32'h5, 32'h6};
    issue(5'b10000, 4'd4, w);
    tick();
    tick();
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_op_ready", op_ready, 1);
    check("midrst_alu_opcode", alu_opcode, 0);
    for (int i = 0; i < 10; i++) tick();
    check("midrst_hi", hi_out, 0);
    check("midrst_lo", lo_out, 0);

    // undefined opcode is swallowed
    alu_result = {32'hA, 32'hB};
    issue(5'b01111, 4'd0, w);
    for (int i = 0; i < 4; i++) tick();
    check("mul2_lo", lo_out, 32'hB);
    alu_result = {32'h77, 32'h88};
    issue(5'b10011, 4'd7, w);
    check("undef_busy", busy, 0);
    check("undef_op_ready", op_ready, 1);
    check("undef_alu_opcode", alu_opcode, 5'b10011);
    for (int i = 0; i < 5; i++) tick();
    check("undef_hi", hi_out, 32'hA);
    check("undef_lo", lo_out, 32'hB);

    // back-to-back: sub offered on the edge the add writeback retires
    alu_result = 64'h11;
    exp_q.push_back({4'd4, 32'h11});
    exp_q.push_back({4'd6, 32'h22});
    issue(5'b00011, 4'd4, w);
    tick();
    wb_ready   = 1'b1;
    alu_result = 64'h22;
    issue(5'b00100, 4'd6, w);
`ifdef ALU_WB_BYPASS_EN
    check("bypass_waits", w, 0);
    check("bypass_no_wb_yet", wb_valid, 0);
    tick();
    check("bypass_wb_again", wb_valid, 1);
`else
    check("bubble_waits", w, 1);
    check("bubble_no_wb_yet", wb_valid, 0);
    tick();
    check("bubble_wb_again", wb_valid, 1);
`endif
    tick();
    wb_ready = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
